// File: rtl/cp0_exc.sv
// Coprocessor-0 exception controller at the M stage: SR/Cause/EPC/PRId,
// mfc0/mtc0 access, and the trap/eret/epc redirect signals for next-PC.
module cp0_exc #(
    parameter logic [31:0] PRID  = 32'h4D49_5037,
    parameter int          IRQ_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [31:0]      pcM,
    input  logic             bdM,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic             eret_req,
    input  logic [IRQ_W-1:0] hw_int,
    output logic             trap,
    output logic             eret,
    output logic [31:0]      epc
);

    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;
    localparam logic [4:0]  ADDR_PRID  = 5'd15;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [IRQ_W-1:0] r_sr_im;
    logic             r_sr_exl;
    logic             r_sr_ie;
    logic             r_cause_bd;
    logic [IRQ_W-1:0] r_cause_ip;
    logic [4:0]       r_cause_exc;
    logic [31:0]      r_epc;

    logic             w_int_req;
    logic             w_trap;
    logic             w_eret;
    logic             w_mtc0;
    logic [31:0]      w_wdata_al;
    logic [31:0]      w_epc_trap;
    logic [31:0]      w_sr;
    logic [31:0]      w_cause;

    // Trap/eret decision; rst_n gating keeps the pipeline from redirecting while in reset.
    always_comb begin
        w_int_req  = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
        w_trap     = (w_int_req | (exc_valid & ~r_sr_exl)) & ~eret_req & rst_n;
        w_eret     = eret_req & ~w_trap;
        w_mtc0     = we & ~w_trap;
        w_wdata_al = wdata & ALIGN_MASK;
        if (bdM) begin
            w_epc_trap = (pcM - 32'd4) & ALIGN_MASK;
        end else begin
            w_epc_trap = pcM & ALIGN_MASK;
        end
    end

    // Register images as seen by mfc0.
    always_comb begin
        w_sr                  = 32'd0;
        w_sr[10 +: IRQ_W]     = r_sr_im;
        w_sr[1]               = r_sr_exl;
        w_sr[0]               = r_sr_ie;
        w_cause               = 32'd0;
        w_cause[31]           = r_cause_bd;
        w_cause[10 +: IRQ_W]  = r_cause_ip;
        w_cause[6:2]          = r_cause_exc;
    end

    // mfc0 read mux, pre-write state.
    always_comb begin
        case (addr)
            ADDR_SR:    rdata = w_sr;
            ADDR_CAUSE: rdata = w_cause;
            ADDR_EPC:   rdata = r_epc;
            ADDR_PRID:  rdata = PRID;
            default:    rdata = 32'd0;
        endcase
    end

    // Redirect outputs; epc forwards a same-cycle mtc0 EPC so a back-to-back eret sees it.
    always_comb begin
        trap = w_trap;
        eret = w_eret;
        if (w_mtc0 && (addr == ADDR_EPC)) begin
            epc = w_wdata_al;
        end else begin
            epc = r_epc;
        end
    end

    // SR: trap sets EXL and flushes the mtc0; eret clears EXL after any mtc0 write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_im  <= '0;
            r_sr_exl <= 1'b0;
            r_sr_ie  <= 1'b0;
        end else if (w_trap) begin
            r_sr_exl <= 1'b1;
        end else begin
            if (w_mtc0 && (addr == ADDR_SR)) begin
                r_sr_im  <= wdata[10 +: IRQ_W];
                r_sr_ie  <= wdata[0];
                r_sr_exl <= wdata[1] & ~w_eret;
            end else if (w_eret) begin
                r_sr_exl <= 1'b0;
            end
        end
    end

    // Cause: IP samples the lines every edge; BD/ExcCode latch on trap only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= 5'd0;
        end else begin
            r_cause_ip <= hw_int;
            if (w_trap) begin
                r_cause_bd  <= bdM;
                r_cause_exc <= w_int_req ? 5'd0 : exc_code;
            end
        end
    end

    // EPC: trap capture has priority over a (flushed) mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc <= 32'd0;
        end else if (w_trap) begin
            r_epc <= w_epc_trap;
        end else if (w_mtc0 && (addr == ADDR_EPC)) begin
            r_epc <= w_wdata_al;
        end
    end

endmodule

// File: tb/tb_cp0_exc.sv
// Directed bench for cp0_exc: a stepped vector table plus reset sequences.
module tb_cp0_exc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pcM;
    logic        bdM;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        eret_req;
    logic [5:0]  hw_int;
    logic        trap;
    logic        eret;
    logic [31:0] epc;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_exc dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .pcM(pcM), .bdM(bdM), .exc_valid(exc_valid),
        .exc_code(exc_code), .eret_req(eret_req), .hw_int(hw_int),
        .trap(trap), .eret(eret), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        bd;
        logic        ev;
        logic [4:0]  ec;
        logic        er;
        logic [5:0]  hw;
        logic        x_trap;
        logic        x_eret;
        logic [31:0] x_epc;
        logic [31:0] x_rdata;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] wd,
                                input logic [31:0] pc, input logic bd, input logic ev,
                                input logic [4:0] ec, input logic er, input logic [5:0] hw,
                                input logic xt, input logic xe, input logic [31:0] xepc,
                                input logic [31:0] xrd);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = wd; v.pc = pc; v.bd = bd; v.ev = ev;
        v.ec = ec; v.er = er; v.hw = hw; v.x_trap = xt; v.x_eret = xe;
        v.x_epc = xepc; v.x_rdata = xrd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; addr = 5'd0; wdata = 32'd0; pcM = 32'd0; bdM = 1'b0;
        exc_valid = 1'b0; exc_code = 5'd0; eret_req = 1'b0; hw_int = 6'd0;
    endtask

    initial begin
        // w  addr   wdata          pc            bd    ev    ec     er    hw        trap  eret  epc            rdata
        vecs[0]  = mk(1'b0, 5'd15, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 32'h4D495037);
        vecs[1]  = mk(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        vecs[2]  = mk(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        vecs[3]  = mk(1'b0, 5'd14, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        vecs[4]  = mk(1'b0, 5'd0, 32'h0, 32'h3010, 1'b0, 1'b1, 5'd12, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 32'h0);
        vecs[5]  = mk(1'b0, 5'd14, 32'h0, 32'h3050, 1'b0, 1'b1, 5'd10, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3010, 32'h3010);
        vecs[6]  = mk(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3010, 32'h30);
        vecs[7]  = mk(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3010, 32'h2);
        vecs[8]  = mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0, 1'b1, 32'h3010, 32'h0);
        vecs[9]  = mk(1'b0, 5'd12, 32'h0, 32'h3024, 1'b1, 1'b1, 5'd10, 1'b0, 6'd0, 1'b1, 1'b0, 32'h3010, 32'h0);
        vecs[10] = mk(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3020, 32'h80000028);
        vecs[11] = mk(1'b0, 5'd14, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3020, 32'h3020);
        vecs[12] = mk(1'b1, 5'd12, 32'h401, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0, 1'b1, 32'h3020, 32'h2);
        vecs[13] = mk(1'b0, 5'd12, 32'h0, 32'h3100, 1'b0, 1'b1, 5'd4, 1'b0, 6'b000001, 1'b1, 1'b0, 32'h3020, 32'h401);
        vecs[14] = mk(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3100, 32'h400);
        vecs[15] = mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0, 1'b1, 32'h3100, 32'h0);
        vecs[16] = mk(1'b0, 5'd13, 32'h0, 32'h3200, 1'b0, 1'b1, 5'd4, 1'b0, 6'b000010, 1'b1, 1'b0, 32'h3100, 32'h0);
        vecs[17] = mk(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3200, 32'h810);
        vecs[18] = mk(1'b1, 5'd14, 32'h3402, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3400, 32'h3200);
        vecs[19] = mk(1'b0, 5'd14, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0, 1'b1, 32'h3400, 32'h3400);
        vecs[20] = mk(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3400, 32'h401);
        vecs[21] = mk(1'b0, 5'd0, 32'h0, 32'h3300, 1'b0, 1'b1, 5'd12, 1'b0, 6'd0, 1'b1, 1'b0, 32'h3400, 32'h0);
        vecs[22] = mk(1'b1, 5'd14, 32'h3507, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0, 1'b1, 32'h3504, 32'h3300);
        vecs[23] = mk(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3504, 32'h401);
        vecs[24] = mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 6'b000001, 1'b0, 1'b1, 32'h3504, 32'h0);
        vecs[25] = mk(1'b1, 5'd12, 32'h0, 32'h3600, 1'b0, 1'b0, 5'd0, 1'b0, 6'b000001, 1'b1, 1'b0, 32'h3504, 32'h401);
        vecs[26] = mk(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3600, 32'h403);
        vecs[27] = mk(1'b0, 5'd14, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3600, 32'h3600);
        vecs[28] = mk(1'b1, 5'd13, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3600, 32'h0);
        vecs[29] = mk(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h3600, 32'h0);

        // Reset held with every trap source asserted.
        idle();
        rst_n = 1'b0;
        hw_int = 6'h3F;
        exc_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_eret", {31'd0, eret}, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Table: inputs at negedge, check combinational outputs mid-phase, state updates at posedge.
        for (int i = 0; i < 30; i++) begin
            we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            pcM = vecs[i].pc; bdM = vecs[i].bd; exc_valid = vecs[i].ev;
            exc_code = vecs[i].ec; eret_req = vecs[i].er; hw_int = vecs[i].hw;
            #2;
            chk($sformatf("v%0d_trap", i), {31'd0, trap}, {31'd0, vecs[i].x_trap});
            chk($sformatf("v%0d_eret", i), {31'd0, eret}, {31'd0, vecs[i].x_eret});
            chk($sformatf("v%0d_epc", i), epc, vecs[i].x_epc);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].x_rdata);
            @(negedge clk);
        end

        // Reset mid-handler (EXL=1 here): clears SR asynchronously and masks interrupts.
        idle();
        addr = 5'd12;
        #1;
        chk("pre_rst_sr", rdata, 32'h403);
        hw_int = 6'b000001;
        rst_n = 1'b0;
        #1;
        chk("midrst_sr", rdata, 32'd0);
        chk("midrst_trap", {31'd0, trap}, 32'd0);
        addr = 5'd14;
        #1;
        chk("midrst_epc", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        addr = 5'd12;
        #1;
        chk("postrst_int_masked", {31'd0, trap}, 32'd0);
        @(negedge clk);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
